// File: rtl/ddr3_arb_nport.sv
// N-port round-robin arbiter in front of a DDR3 user (app_*) interface.
// Bursts are issued one port at a time; read data is steered back to the
// requesting port through a tag FIFO that holds the port index of every
// outstanding read beat.
module ddr3_arb_nport #(
   parameter int NPORT     = 4,
   parameter int ADDR_W    = 29,
   parameter int DATA_W    = 256,
   parameter int ADDR_STEP = 8,
   parameter int TAG_DEPTH = 32
) (
   input  logic                      clk,
   input  logic                      ddr_rst,
   input  logic                      init_calib_complete,
   input  logic [NPORT-1:0]          port_req,
   input  logic [NPORT-1:0]          port_wr,
   input  logic [NPORT*ADDR_W-1:0]   port_addr,
   input  logic [NPORT*8-1:0]        port_len,
   output logic [NPORT-1:0]          port_grant,
   output logic [NPORT-1:0]          port_done,
   input  logic [NPORT*DATA_W-1:0]   port_wdata,
   output logic [NPORT-1:0]          port_wpop,
   output logic [DATA_W-1:0]         port_rdata,
   output logic [NPORT-1:0]          port_rvalid,
   output logic [2:0]                app_cmd,
   output logic                      app_en,
   output logic [ADDR_W-1:0]         app_addr,
   input  logic                      app_rdy,
   output logic [DATA_W-1:0]         app_wdf_data,
   output logic                      app_wdf_wren,
   output logic                      app_wdf_end,
   input  logic                      app_wdf_rdy,
   input  logic [DATA_W-1:0]         app_rd_data,
   input  logic                      app_rd_data_valid,
   output logic                      err_sticky
);

   localparam int IDX_W  = $clog2(NPORT);
   localparam int TAG_AW = $clog2(TAG_DEPTH);

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [IDX_W-1:0]    r_port, r_last, w_pick, w_tag_head;
   logic                w_pick_vld, w_start;
   logic [ADDR_W-1:0]   r_addr, w_req_addr;
   logic [7:0]          r_cnt, w_req_len;
   logic                r_grant;
   logic [IDX_W-1:0]    r_tag_mem [TAG_DEPTH];
   logic [TAG_AW:0]     r_wptr, r_rptr;
   logic                w_full, w_empty, w_push, w_pop;
   logic                w_wr_acc, w_rd_acc;
   logic [NPORT-1:0]    r_rvalid;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_err;

   function automatic logic [NPORT-1:0] f_onehot(input logic [IDX_W-1:0] idx);
      logic [NPORT-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin pick: first requester strictly above the last grant, wrapping.
   always_comb begin
      w_pick     = '0;
      w_pick_vld = 1'b0;
      for (int i = 1; i <= NPORT; i++) begin
         if (!w_pick_vld && port_req[(int'(r_last) + i) % NPORT]) begin
            w_pick     = IDX_W'((int'(r_last) + i) % NPORT);
            w_pick_vld = 1'b1;
         end
      end
   end

   assign w_start    = (r_state == IDLE) && init_calib_complete && w_pick_vld;
   assign w_req_addr = port_addr[w_pick*ADDR_W +: ADDR_W];
   assign w_req_len  = port_len[w_pick*8 +: 8];

   // Tag FIFO status; the extra pointer bit separates full from empty.
   assign w_empty    = (r_wptr == r_rptr);
   assign w_full     = (r_wptr[TAG_AW] != r_rptr[TAG_AW]) &&
                       (r_wptr[TAG_AW-1:0] == r_rptr[TAG_AW-1:0]);
   assign w_tag_head = r_tag_mem[r_rptr[TAG_AW-1:0]];

   assign w_wr_acc = (r_state == WR_BURST) && app_rdy && app_wdf_rdy;
   assign w_rd_acc = (r_state == RD_BURST) && !w_full && app_rdy;
   assign w_push   = w_rd_acc;
   assign w_pop    = app_rd_data_valid && !w_empty;

   // Next-state decode for the burst sequencer.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_start) begin
               if (w_req_len == 8'd0)   w_state_nxt = DONE;
               else if (port_wr[w_pick]) w_state_nxt = WR_BURST;
               else                      w_state_nxt = RD_BURST;
            end
         end
         WR_BURST: if (w_wr_acc && (r_cnt == 8'd1)) w_state_nxt = DONE;
         RD_BURST: if (w_rd_acc && (r_cnt == 8'd1)) w_state_nxt = DONE;
         DONE:     w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // DDR command/data outputs, decoded from the current state.
   always_comb begin
      app_en       = 1'b0;
      app_cmd      = 3'd0;
      app_wdf_wren = 1'b0;
      app_wdf_end  = 1'b0;
      app_wdf_data = '0;
      unique case (r_state)
         WR_BURST: begin
            app_en       = 1'b1;
            app_wdf_wren = 1'b1;
            app_wdf_end  = 1'b1;
            app_wdf_data = port_wdata[r_port*DATA_W +: DATA_W];
         end
         RD_BURST: begin
            app_cmd = 3'd1;
            app_en  = !w_full;
         end
         default: ;
      endcase
   end

   assign app_addr    = r_addr;
   assign port_grant  = r_grant ? f_onehot(r_port) : '0;
   assign port_done   = (r_state == DONE) ? f_onehot(r_port) : '0;
   assign port_wpop   = w_wr_acc ? f_onehot(r_port) : '0;
   assign port_rvalid = r_rvalid;
   assign port_rdata  = r_rdata;
   assign err_sticky  = r_err;

   // Sequencer state, latched request and beat bookkeeping.
   always_ff @(posedge clk or posedge ddr_rst) begin
      if (ddr_rst) begin
         r_state <= IDLE;
         r_port  <= '0;
         r_last  <= IDX_W'(NPORT - 1);
         r_addr  <= '0;
         r_cnt   <= '0;
         r_grant <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_start;
         if (w_start) begin
            r_port <= w_pick;
            r_last <= w_pick;
            r_addr <= w_req_addr;
            r_cnt  <= w_req_len;
         end else if (w_wr_acc || w_rd_acc) begin
            r_addr <= r_addr + ADDR_W'(ADDR_STEP);
            r_cnt  <= r_cnt - 8'd1;
         end
      end
   end

   // Tag FIFO pointers; push and pop in one cycle leave occupancy unchanged.
   always_ff @(posedge clk or posedge ddr_rst) begin
      if (ddr_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Tag storage needs no reset; only entries between the pointers are read.
   always_ff @(posedge clk) begin
      if (w_push) r_tag_mem[r_wptr[TAG_AW-1:0]] <= r_port;
   end

   // Registered read return and sticky flag for orphan read data.
   always_ff @(posedge clk or posedge ddr_rst) begin
      if (ddr_rst) begin
         r_rvalid <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= w_pop ? f_onehot(w_tag_head) : '0;
         if (w_pop) r_rdata <= app_rd_data;
         if (app_rd_data_valid && w_empty) r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ddr3_arb_nport.sv
// Scoreboard bench for ddr3_arb_nport: a driver feeds per-port command queues,
// FWFT write data and a DDR model; a negedge monitor checks every DDR beat,
// grant, done and read return against expectations queued at grant time.
module tb_ddr3_arb_nport;

   localparam int NP = 4, AW = 29, DW = 256, STEP = 8, TD = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              ddr_rst, calib;
   logic [NP-1:0]     port_req, port_wr, port_grant, port_done, port_wpop, port_rvalid;
   logic [NP*AW-1:0]  port_addr;
   logic [NP*8-1:0]   port_len;
   logic [NP*DW-1:0]  port_wdata;
   logic [DW-1:0]     port_rdata, app_wdf_data, app_rd_data;
   logic [2:0]        app_cmd;
   logic              app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic              app_rd_data_valid, err_sticky;
   logic [AW-1:0]     app_addr;

   ddr3_arb_nport #(.NPORT(NP), .ADDR_W(AW), .DATA_W(DW), .ADDR_STEP(STEP), .TAG_DEPTH(TD)) dut (
      .clk(clk), .ddr_rst(ddr_rst), .init_calib_complete(calib),
      .port_req(port_req), .port_wr(port_wr), .port_addr(port_addr), .port_len(port_len),
      .port_grant(port_grant), .port_done(port_done), .port_wdata(port_wdata),
      .port_wpop(port_wpop), .port_rdata(port_rdata), .port_rvalid(port_rvalid),
      .app_cmd(app_cmd), .app_en(app_en), .app_addr(app_addr), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
      .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
      .app_rd_data_valid(app_rd_data_valid), .err_sticky(err_sticky));

   typedef struct {logic wr; logic [AW-1:0] addr; int len;} cmd_t;
   typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wbeat_t;
   typedef struct {int port; logic [DW-1:0] data;} rret_t;

   int n_tests = 0, n_fail = 0;
   cmd_t          cq [NP][$];
   wbeat_t        wexp[$];
   logic [AW-1:0] rexp[$];
   rret_t         rvexp[$];
   logic [DW-1:0] ddr_q[$];
   int            gnt_log[$], rv_log[$];
   int            wcnt[NP], wexp_cnt[NP];
   bit            cur_active, cur_wr, exp_err, prev_pop;
   int            cur_port, cur_left, last_gnt, occ;
   int            n_rd_acc, n_wr_acc, n_rvalid, n_wpop, n_en, n_grant, n_done;
   logic [NP-1:0] req_snap;
   logic          calib_snap;
   int            rdy_mode;
   bit            ret_en, spur, calib_rand;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chkd(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Content of the n-th word of port p's write-data stream.
   function automatic logic [DW-1:0] wdat(input int p, input int n);
      logic [DW-1:0] d;
      for (int j = 0; j < DW / 32; j++)
         d[j*32 +: 32] = 32'(p * 32'h0100_0193) ^ 32'(n * 32'h9E37_79B9) ^ 32'(j * 32'h85EB_CA6B);
      return d;
   endfunction

   function automatic logic [DW-1:0] rdat();
      logic [DW-1:0] d;
      for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic bit cq_empty();
      for (int p = 0; p < NP; p++) if (cq[p].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      req_snap   <= port_req;
      calib_snap <= calib;
   end

   // Driver: request lines from command queues, FWFT data, DDR handshakes.
   initial forever begin
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
         port_req[p] = (cq[p].size() != 0);
         if (cq[p].size() != 0) begin
            port_wr[p]              = cq[p][0].wr;
            port_addr[p*AW +: AW]   = cq[p][0].addr;
            port_len[p*8 +: 8]      = 8'(cq[p][0].len);
         end
         port_wdata[p*DW +: DW] = wdat(p, wcnt[p]);
      end
      case (rdy_mode)
         1: begin app_rdy = ($urandom_range(0, 3) != 0); app_wdf_rdy = ($urandom_range(0, 3) != 0); end
         2: begin app_rdy = 1'b1; app_wdf_rdy = ~app_wdf_rdy; end
         default: begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
      endcase
      if (calib_rand) calib = ($urandom_range(0, 3) != 0);
      app_rd_data_valid = 1'b0;
      if (spur) begin
         app_rd_data_valid = 1'b1;
         app_rd_data       = rdat();
         spur              = 1'b0;
      end else if (ret_en && ddr_q.size() != 0 && $urandom_range(0, 1) == 1) begin
         app_rd_data_valid = 1'b1;
         app_rd_data       = ddr_q.pop_front();
      end
   end

   task automatic model_reset();
      wexp.delete(); rexp.delete(); rvexp.delete();
      for (int p = 0; p < NP; p++) begin cq[p].delete(); wexp_cnt[p] = wcnt[p]; end
      cur_active = 0; cur_left = 0; last_gnt = NP - 1; occ = 0; exp_err = 0; prev_pop = 0;
   endtask

   task automatic mon_step();
      int e, occ0, left0;
      bit exp_en, acc_wr, acc_rd, pop_now;
      cmd_t c; wbeat_t w; rret_t r; logic [DW-1:0] d;
      occ0 = occ;
      chk("err_sticky", 64'(err_sticky), 64'(exp_err));
      chk("rvalid_timing", 64'(port_rvalid != 0), 64'(prev_pop));
      if (port_rvalid != 0) begin
         n_rvalid++;
         for (int p = 0; p < NP; p++) if (port_rvalid[p]) rv_log.push_back(p);
         chk("rvalid_expected", 64'(rvexp.size() != 0), 1);
         if (rvexp.size() != 0) begin
            r = rvexp.pop_front();
            chk("rvalid_port", 64'(port_rvalid), 64'(1) << r.port);
            chkd("rdata", port_rdata, r.data);
         end
      end
      if (port_grant != 0) begin
         n_grant++;
         for (int p = 0; p < NP; p++) if (port_grant[p]) gnt_log.push_back(p);
         e = -1;
         for (int i = 1; i <= NP; i++)
            if (e < 0 && req_snap[(last_gnt + i) % NP]) e = (last_gnt + i) % NP;
         chk("grant_calib", 64'(calib_snap), 1);
         chk("grant_while_busy", 64'(cur_active), 0);
         chk("grant_port", 64'(port_grant), (e < 0) ? 64'(0) : (64'(1) << e));
         if (e >= 0 && cq[e].size() != 0) begin
            c = cq[e].pop_front();
            last_gnt = e; cur_active = 1; cur_wr = c.wr; cur_port = e; cur_left = c.len;
            for (int k = 0; k < c.len; k++) begin
               if (c.wr) begin
                  w.addr = c.addr + AW'(k * STEP);
                  w.data = wdat(e, wexp_cnt[e]);
                  wexp_cnt[e]++;
                  wexp.push_back(w);
               end else rexp.push_back(c.addr + AW'(k * STEP));
            end
         end
      end
      left0  = cur_left;
      exp_en = cur_active && left0 > 0 && (cur_wr || occ0 < TD);
      if (app_en) n_en++;
      chk("app_en", 64'(app_en), 64'(exp_en));
      chk("app_wdf_wren", 64'(app_wdf_wren), 64'(exp_en && cur_wr));
      chk("app_wdf_end", 64'(app_wdf_end), 64'(exp_en && cur_wr));
      if (exp_en) chk("app_cmd", 64'(app_cmd), cur_wr ? 64'(0) : 64'(1));
      acc_wr = app_en && app_cmd == 3'd0 && app_rdy && app_wdf_rdy;
      acc_rd = app_en && app_cmd == 3'd1 && app_rdy;
      chk("wpop", 64'(port_wpop), acc_wr ? (64'(1) << cur_port) : 64'(0));
      for (int p = 0; p < NP; p++) if (port_wpop[p]) begin wcnt[p]++; n_wpop++; end
      if (acc_wr) begin
         n_wr_acc++; cur_left--;
         chk("wbeat_expected", 64'(wexp.size() != 0), 1);
         if (wexp.size() != 0) begin
            w = wexp.pop_front();
            chk("wr_addr", 64'(app_addr), 64'(w.addr));
            chkd("wr_data", app_wdf_data, w.data);
         end
      end
      if (acc_rd) begin
         n_rd_acc++; cur_left--;
         chk("tag_room", 64'(occ0 < TD), 1);
         chk("rbeat_expected", 64'(rexp.size() != 0), 1);
         if (rexp.size() != 0) chk("rd_addr", 64'(app_addr), 64'(rexp.pop_front()));
         d = rdat();
         ddr_q.push_back(d);
         r.port = cur_port; r.data = d;
         rvexp.push_back(r);
      end
      pop_now = app_rd_data_valid && occ0 > 0;
      if (app_rd_data_valid && occ0 == 0) exp_err = 1;
      prev_pop = pop_now;
      occ = occ0 + int'(acc_rd) - int'(pop_now);
      chk("done_pulse", 64'(port_done != 0), 64'(cur_active && left0 == 0));
      if (port_done != 0) begin
         n_done++;
         chk("done_port", 64'(port_done), 64'(1) << cur_port);
         cur_active = 0;
      end
   endtask

   // Monitor: samples on the falling edge, away from the DUT's active edge.
   initial forever begin
      @(negedge clk);
      if (ddr_rst) begin
         chk("reset_outputs", 64'(|{port_grant, port_done, port_wpop, port_rvalid, port_rdata,
             app_cmd, app_en, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end, err_sticky}), 0);
         model_reset();
      end else mon_step();
   end

   task automatic wait_idle(input int limit);
      int t;
      t = 0;
      while (t < limit && !(cq_empty() && !cur_active && rvexp.size() == 0 && !prev_pop)) begin
         @(posedge clk); t++;
      end
      chk("idle_reached", 64'(t < limit), 1);
      repeat (3) @(posedge clk);
   endtask

   task automatic reset_dut();
      @(posedge clk); #2 ddr_rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 ddr_rst = 1'b0;
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, b1, t;
      cmd_t c;
      ddr_rst = 1'b1; calib = 1'b0; port_req = '0; port_wr = '0; port_addr = '0;
      port_len = '0; port_wdata = '0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      app_rd_data = '0; app_rd_data_valid = 1'b0;
      rdy_mode = 0; ret_en = 1; spur = 0; calib_rand = 0;
      for (int p = 0; p < NP; p++) begin wcnt[p] = 0; wexp_cnt[p] = 0; end
      repeat (3) @(posedge clk);
      #2 ddr_rst = 1'b0;
      calib = 1'b1;

      // Port 0 write, 4 beats at 0x100.
      b0 = n_wr_acc; b1 = n_wpop;
      c.wr = 1; c.addr = 'h100; c.len = 4; cq[0].push_back(c);
      wait_idle(200);
      chk("p1_wbeats", 64'(n_wr_acc - b0), 4);
      chk("p1_wpops", 64'(n_wpop - b1), 4);

      // All four ports read one beat each right after reset.
      reset_dut();
      gnt_log.delete(); rv_log.delete();
      for (int p = 0; p < NP; p++) begin
         c.wr = 0; c.addr = AW'($urandom); c.len = 1; cq[p].push_back(c);
      end
      wait_idle(300);
      chk("p2_grant_count", 64'(gnt_log.size()), 4);
      chk("p2_rvalid_count", 64'(rv_log.size()), 4);
      for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("p2_grant_order", 64'(gnt_log[i]), 64'(i));
      for (int i = 0; i < 4 && i < rv_log.size(); i++) chk("p2_rvalid_order", 64'(rv_log[i]), 64'(i));

      // Write of 3 beats against a toggling write-data ready.
      rdy_mode = 2; b0 = n_wr_acc; b1 = n_wpop;
      c.wr = 1; c.addr = AW'($urandom); c.len = 3; cq[2].push_back(c);
      wait_idle(200);
      chk("p3_wbeats", 64'(n_wr_acc - b0), 3);
      chk("p3_wpops", 64'(n_wpop - b1), 3);
      rdy_mode = 0;

      // 40-beat read while the DDR withholds data: stalls at tag FIFO depth.
      ret_en = 0; b0 = n_rd_acc; b1 = n_rvalid;
      c.wr = 0; c.addr = AW'($urandom); c.len = 40; cq[1].push_back(c);
      repeat (150) @(posedge clk);
      chk("p4_reads_at_full", 64'(n_rd_acc - b0), 32);
      @(negedge clk);
      chk("p4_app_en_low", 64'(app_en), 0);
      ret_en = 1;
      wait_idle(1000);
      chk("p4_reads_total", 64'(n_rd_acc - b0), 40);
      chk("p4_rvalid_total", 64'(n_rvalid - b1), 40);

      // Orphan read data with nothing outstanding.
      b1 = n_rvalid;
      @(posedge clk); #2 spur = 1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("p5_err_set", 64'(err_sticky), 1);
      chk("p5_no_rvalid", 64'(n_rvalid - b1), 0);
      reset_dut();
      @(negedge clk);
      chk("p5_err_cleared", 64'(err_sticky), 0);

      // Zero-length request: grant and done, no command.
      b0 = n_en; b1 = n_grant; t = n_done;
      c.wr = 1; c.addr = AW'($urandom); c.len = 0; cq[3].push_back(c);
      wait_idle(100);
      chk("p6_no_app_en", 64'(n_en - b0), 0);
      chk("p6_grants", 64'(n_grant - b1), 1);
      chk("p6_dones", 64'(n_done - t), 1);

      // Randomized traffic with random handshakes and calibration drops.
      rdy_mode = 1; calib_rand = 1;
      for (int i = 0; i < 120; i++) begin
         c.wr   = $urandom_range(0, 1);
         c.addr = ($urandom_range(0, 3) == 0) ? AW'(29'h1FFF_FFF0 + $urandom_range(0, 15))
                                             : AW'($urandom);
         c.len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : $urandom_range(0, 6);
         cq[$urandom_range(0, NP - 1)].push_back(c);
         repeat ($urandom_range(0, 12)) @(posedge clk);
      end
      calib_rand = 0; calib = 1;
      wait_idle(30000);
      rdy_mode = 0;

      // Reset in the middle of a write burst.
      b0 = n_wr_acc;
      c.wr = 1; c.addr = AW'($urandom); c.len = 20; cq[0].push_back(c);
      t = 0;
      while (n_wr_acc - b0 < 3 && t < 100) begin @(posedge clk); t++; end
      chk("p8_burst_started", 64'(t < 100), 1);
      #2 ddr_rst = 1'b1;
      #1 chk("p8_async_abort", 64'(|{app_en, app_wdf_wren, port_wpop, port_grant}), 0);
      repeat (2) @(posedge clk);
      #2 ddr_rst = 1'b0;

      // Reset with reads in flight: their late data must flag an error.
      ret_en = 0; b0 = n_rd_acc;
      c.wr = 0; c.addr = AW'($urandom); c.len = 6; cq[2].push_back(c);
      t = 0;
      while (n_rd_acc - b0 < 4 && t < 100) begin @(posedge clk); t++; end
      chk("p8_reads_started", 64'(t < 100), 1);
      #2 ddr_rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 ddr_rst = 1'b0;
      ret_en = 1;
      t = 0;
      while (ddr_q.size() != 0 && t < 200) begin @(posedge clk); t++; end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("p8_inflight_err", 64'(err_sticky), 1);
      reset_dut();
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
